// File: rtl/hilo_muldiv_unit.sv
// MIPS multiply/divide unit producing HI/LO write data: MUL_LAT cycles for MULT(U), 34 for DIV(U), 1 for MTHI/MTLO.
// No queueing: start is sampled only in IDLE, busy holds the pipe, flush aborts and suppresses any write that cycle.
module hilo_muldiv_unit #(
  parameter int MUL_LAT  = 2,
  parameter int DIV_ITER = 32
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [2:0]  i_op,
  input  logic [31:0] i_src_a,
  input  logic [31:0] i_src_b,
  input  logic        i_flush,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_hi_wdata,
  output logic [31:0] o_lo_wdata,
  output logic        o_hi_we,
  output logic        o_lo_we
);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_op;
  logic [31:0] r_a, r_b, r_quo, r_rem, r_dvs, r_hi, r_lo;
  logic [5:0]  r_cnt;

  logic        w_accept, w_is_div, w_load, w_done, w_sgn, w_neg_q, w_neg_r;
  logic [2:0]  w_mop;
  logic [31:0] w_ma, w_mb, w_mag_a, w_mag_b, w_q_fix, w_r_fix, w_hi_res, w_lo_res;
  logic [32:0] w_shift, w_diff;
  logic [63:0] w_prod;

  assign w_accept = (r_state == S_IDLE) && i_start && !i_flush && (i_op <= OP_MTLO);
  assign w_is_div = (i_op == OP_DIV) || (i_op == OP_DIVU);
  assign w_mag_a  = ((i_op == OP_DIV) && i_src_a[31]) ? -i_src_a : i_src_a;
  assign w_mag_b  = ((i_op == OP_DIV) && i_src_b[31]) ? -i_src_b : i_src_b;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          if (w_is_div)                                  w_state_nxt = S_DIV;
          else if ((i_op == OP_MULT) || (i_op == OP_MULTU)) w_state_nxt = (MUL_LAT == 1) ? S_DONE : S_MUL;
          else                                           w_state_nxt = S_DONE;
        end
        S_MUL:   if (r_cnt <= 6'd1) w_state_nxt = S_DONE;
        S_DIV:   if (r_cnt == 6'd0) w_state_nxt = S_FIX;
        S_FIX:   w_state_nxt = S_DONE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_done   = (r_state == S_DONE) && !i_flush;
    o_busy   = (r_state != S_IDLE);
    o_done   = w_done;
    o_hi_we  = w_done && (r_op != OP_MTLO);
    o_lo_we  = w_done && (r_op != OP_MTHI);
  end

  assign o_hi_wdata = r_hi;
  assign o_lo_wdata = r_lo;

  // With MUL_LAT=1 the product is taken straight from the ports on the accept edge.
  assign w_mop  = (r_state == S_IDLE) ? i_op    : r_op;
  assign w_ma   = (r_state == S_IDLE) ? i_src_a : r_a;
  assign w_mb   = (r_state == S_IDLE) ? i_src_b : r_b;
  assign w_sgn  = (w_mop == OP_MULT);
  assign w_prod = {{32{w_sgn & w_ma[31]}}, w_ma} * {{32{w_sgn & w_mb[31]}}, w_mb};

  assign w_shift = {r_rem, r_quo[31]};
  assign w_diff  = w_shift - {1'b0, r_dvs};
  assign w_neg_q = (r_op == OP_DIV) && (r_a[31] ^ r_b[31]);
  assign w_neg_r = (r_op == OP_DIV) && r_a[31];
  assign w_q_fix = w_neg_q ? -r_quo : r_quo;
  assign w_r_fix = w_neg_r ? -r_rem : r_rem;

  always_comb begin
    w_hi_res = r_hi;
    w_lo_res = r_lo;
    if (r_state == S_FIX) begin
      if (r_b == 32'd0) begin
        w_hi_res = r_a;
        w_lo_res = 32'hFFFF_FFFF;
      end else begin
        w_hi_res = w_r_fix;
        w_lo_res = w_q_fix;
      end
    end else begin
      case (w_mop)
        OP_MTHI: w_hi_res = w_ma;
        OP_MTLO: w_lo_res = w_ma;
        default: {w_hi_res, w_lo_res} = w_prod;
      endcase
    end
  end

  assign w_load = (w_state_nxt == S_DONE) && (r_state != S_DONE);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_op  <= 3'd0;
      r_a   <= 32'd0;
      r_b   <= 32'd0;
      r_quo <= 32'd0;
      r_rem <= 32'd0;
      r_dvs <= 32'd0;
      r_cnt <= 6'd0;
      r_hi  <= 32'd0;
      r_lo  <= 32'd0;
    end else begin
      if (w_accept) begin
        r_op  <= i_op;
        r_a   <= i_src_a;
        r_b   <= i_src_b;
        r_quo <= w_mag_a;
        r_dvs <= w_mag_b;
        r_rem <= 32'd0;
        r_cnt <= w_is_div ? 6'(DIV_ITER - 1) : 6'(MUL_LAT - 1);
      end else if (r_state == S_MUL) begin
        r_cnt <= r_cnt - 6'd1;
      end else if (r_state == S_DIV) begin
        r_cnt <= r_cnt - 6'd1;
        if (!w_diff[32]) begin
          r_rem <= w_diff[31:0];
          r_quo <= {r_quo[30:0], 1'b1};
        end else begin
          r_rem <= w_shift[31:0];
          r_quo <= {r_quo[30:0], 1'b0};
        end
      end
      if (w_load) begin
        r_hi <= w_hi_res;
        r_lo <= w_lo_res;
      end
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit: cycle numbering counts the period after the accept edge as cycle 1.
module tb_hilo_muldiv_unit;

  localparam logic [2:0] MULT = 3'd0, MULTU = 3'd1, DIV = 3'd2, DIVU = 3'd3, MTHI = 3'd4, MTLO = 3'd5;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  op;
  logic [31:0] src_a, src_b;
  logic        busy, done, hi_we, lo_we;
  logic [31:0] hi_wdata, lo_wdata;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  hilo_muldiv_unit #(.MUL_LAT(2), .DIV_ITER(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_op(op), .i_src_a(src_a), .i_src_b(src_b),
    .i_flush(flush), .o_busy(busy), .o_done(done), .o_hi_wdata(hi_wdata), .o_lo_wdata(lo_wdata),
    .o_hi_we(hi_we), .o_lo_we(lo_we)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single edge, then scramble the operand ports.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; src_a = a; src_b = b;
    step();
    start = 1'b0; src_a = 32'hA5A5_A5A5; src_b = 32'h5A5A_5A5A;
  endtask

  // Steps until done is seen; leaves time inside the done cycle. cyc = -1 on timeout.
  task automatic wait_done(input int k0, input int max, output int cyc, output int busy_low);
    cyc = -1;
    busy_low = 0;
    for (int k = k0; k <= max && cyc < 0; k++) begin
      if (done) cyc = k;
      else begin
        if (!busy) busy_low++;
        step();
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; flush = 1'b0; op = 3'd0; src_a = 32'd0; src_b = 32'd0;
    repeat (2) step();
    n_vec++; if (busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (done !== 1'b0)      begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_vec++; if (hi_we !== 1'b0)     begin n_err++; $display("FAIL reset_hi_we: got %b want 0", hi_we); end
    n_vec++; if (lo_we !== 1'b0)     begin n_err++; $display("FAIL reset_lo_we: got %b want 0", lo_we); end
    n_vec++; if (hi_wdata !== 32'd0) begin n_err++; $display("FAIL reset_hi: got %h want 0", hi_wdata); end
    n_vec++; if (lo_wdata !== 32'd0) begin n_err++; $display("FAIL reset_lo: got %h want 0", lo_wdata); end
    rst = 1'b1;
    step();
  endtask

  task automatic test_mul();
    int c, bl;
    issue(MULT, 32'hFFFF_FFFE, 32'h0000_0003);
    wait_done(1, 20, c, bl);
    n_vec++; if (c !== 2)                 begin n_err++; $display("FAIL mult_cycle: got %0d want 2", c); end
    n_vec++; if (bl !== 0)                begin n_err++; $display("FAIL mult_busy: busy low %0d cycles want 0", bl); end
    n_vec++; if ({hi_we, lo_we} !== 2'b11) begin n_err++; $display("FAIL mult_we: got %b want 11", {hi_we, lo_we}); end
    n_vec++; if (hi_wdata !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mult_hi: got %h want ffffffff", hi_wdata); end
    n_vec++; if (lo_wdata !== 32'hFFFF_FFFA) begin n_err++; $display("FAIL mult_lo: got %h want fffffffa", lo_wdata); end
    step();
    n_vec++; if ({busy, done} !== 2'b00)  begin n_err++; $display("FAIL mult_after: busy/done %b want 00", {busy, done}); end
    issue(MULTU, 32'hFFFF_FFFE, 32'h0000_0003);
    wait_done(1, 20, c, bl);
    n_vec++; if (c !== 2)                 begin n_err++; $display("FAIL multu_cycle: got %0d want 2", c); end
    n_vec++; if (hi_wdata !== 32'h0000_0002) begin n_err++; $display("FAIL multu_hi: got %h want 00000002", hi_wdata); end
    n_vec++; if (lo_wdata !== 32'hFFFF_FFFA) begin n_err++; $display("FAIL multu_lo: got %h want fffffffa", lo_wdata); end
    step();
  endtask

  task automatic test_div();
    int c, bl;
    issue(DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(1, 60, c, bl);
    n_vec++; if (c !== 34)                begin n_err++; $display("FAIL div_cycle: got %0d want 34", c); end
    n_vec++; if (bl !== 0)                begin n_err++; $display("FAIL div_busy: busy low %0d cycles want 0", bl); end
    n_vec++; if ({hi_we, lo_we} !== 2'b11) begin n_err++; $display("FAIL div_we: got %b want 11", {hi_we, lo_we}); end
    n_vec++; if (lo_wdata !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_lo: got %h want fffffffd", lo_wdata); end
    n_vec++; if (hi_wdata !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div_hi: got %h want ffffffff", hi_wdata); end
    step();
    n_vec++; if (busy !== 1'b0)           begin n_err++; $display("FAIL div_busy_fall: got %b want 0", busy); end
    issue(DIVU, 32'd100, 32'd7);
    wait_done(1, 60, c, bl);
    n_vec++; if (c !== 34)                begin n_err++; $display("FAIL divu_cycle: got %0d want 34", c); end
    n_vec++; if (lo_wdata !== 32'd14)     begin n_err++; $display("FAIL divu_lo: got %0d want 14", lo_wdata); end
    n_vec++; if (hi_wdata !== 32'd2)      begin n_err++; $display("FAIL divu_hi: got %0d want 2", hi_wdata); end
    step();
  endtask

  task automatic test_div_special();
    int c, bl;
    issue(DIVU, 32'h1234_5678, 32'd0);
    wait_done(1, 60, c, bl);
    n_vec++; if (c !== 34)                begin n_err++; $display("FAIL divz_cycle: got %0d want 34", c); end
    n_vec++; if (lo_wdata !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL divz_lo: got %h want ffffffff", lo_wdata); end
    n_vec++; if (hi_wdata !== 32'h1234_5678) begin n_err++; $display("FAIL divz_hi: got %h want 12345678", hi_wdata); end
    step();
    issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(1, 60, c, bl);
    n_vec++; if (lo_wdata !== 32'h8000_0000) begin n_err++; $display("FAIL divovf_lo: got %h want 80000000", lo_wdata); end
    n_vec++; if (hi_wdata !== 32'd0)      begin n_err++; $display("FAIL divovf_hi: got %h want 0", hi_wdata); end
    step();
  endtask

  task automatic test_mthi_mtlo();
    int c, bl;
    issue(MTHI, 32'hDEAD_BEEF, 32'd0);
    wait_done(1, 10, c, bl);
    n_vec++; if (c !== 1)                 begin n_err++; $display("FAIL mthi_cycle: got %0d want 1", c); end
    n_vec++; if ({hi_we, lo_we} !== 2'b10) begin n_err++; $display("FAIL mthi_we: got %b want 10", {hi_we, lo_we}); end
    n_vec++; if (hi_wdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL mthi_hi: got %h want deadbeef", hi_wdata); end
    n_vec++; if (lo_wdata !== 32'h8000_0000) begin n_err++; $display("FAIL mthi_lo_hold: got %h want 80000000", lo_wdata); end
    step();
    issue(MTLO, 32'h0BAD_F00D, 32'd0);
    wait_done(1, 10, c, bl);
    n_vec++; if (c !== 1)                 begin n_err++; $display("FAIL mtlo_cycle: got %0d want 1", c); end
    n_vec++; if ({hi_we, lo_we} !== 2'b01) begin n_err++; $display("FAIL mtlo_we: got %b want 01", {hi_we, lo_we}); end
    n_vec++; if (lo_wdata !== 32'h0BAD_F00D) begin n_err++; $display("FAIL mtlo_lo: got %h want 0badf00d", lo_wdata); end
    n_vec++; if (hi_wdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL mtlo_hi_hold: got %h want deadbeef", hi_wdata); end
    step();
  endtask

  task automatic test_busy_ignore();
    int c, bl, extra;
    issue(DIVU, 32'd100, 32'd7);
    start = 1'b1; op = MTHI; src_a = 32'h1111_1111;
    repeat (3) step();
    start = 1'b0;
    wait_done(4, 60, c, bl);
    n_vec++; if (c !== 34)                begin n_err++; $display("FAIL ignore_cycle: got %0d want 34", c); end
    n_vec++; if (lo_wdata !== 32'd14)     begin n_err++; $display("FAIL ignore_lo: got %0d want 14", lo_wdata); end
    n_vec++; if (hi_wdata !== 32'd2)      begin n_err++; $display("FAIL ignore_hi: got %0d want 2", hi_wdata); end
    extra = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (done || busy) extra++;
    end
    n_vec++; if (extra !== 0)             begin n_err++; $display("FAIL ignore_extra: %0d busy/done cycles want 0", extra); end
  endtask

  task automatic test_flush();
    int c, bl, we_cnt;
    issue(DIV, 32'hFFFF_FFF9, 32'd2);
    we_cnt = 0;
    for (int k = 1; k < 10; k++) begin
      if (hi_we || lo_we || done) we_cnt++;
      step();
    end
    flush = 1'b1;
    #1;
    if (hi_we || lo_we || done) we_cnt++;
    step();
    flush = 1'b0;
    n_vec++; if (busy !== 1'b0)           begin n_err++; $display("FAIL flush_busy: got %b want 0 in cycle 11", busy); end
    for (int k = 0; k < 40; k++) begin
      if (hi_we || lo_we || done) we_cnt++;
      step();
    end
    n_vec++; if (we_cnt !== 0)            begin n_err++; $display("FAIL flush_we: %0d pulses want 0", we_cnt); end
    issue(DIVU, 32'd100, 32'd7);
    wait_done(1, 60, c, bl);
    n_vec++; if (c !== 34)                begin n_err++; $display("FAIL flushdone_cycle: got %0d want 34", c); end
    flush = 1'b1;
    #1;
    n_vec++; if ({done, hi_we, lo_we} !== 3'b000) begin n_err++; $display("FAIL flushdone_we: got %b want 000", {done, hi_we, lo_we}); end
    step();
    flush = 1'b0;
    n_vec++; if (busy !== 1'b0)           begin n_err++; $display("FAIL flushdone_busy: got %b want 0", busy); end
    start = 1'b1; op = MTHI; src_a = 32'h2222_2222; flush = 1'b1;
    step();
    start = 1'b0; flush = 1'b0;
    n_vec++; if ({busy, done} !== 2'b00)  begin n_err++; $display("FAIL flushstart: busy/done %b want 00", {busy, done}); end
  endtask

  task automatic test_illegal();
    for (int k = 6; k < 8; k++) begin
      start = 1'b1; op = 3'(k); src_a = 32'h3333_3333;
      step();
      start = 1'b0;
      n_vec++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL illegal_op%0d: busy/done %b want 00", k, {busy, done}); end
    end
  endtask

  task automatic test_reset_mid();
    int c, bl;
    issue(DIV, 32'hFFFF_FFF9, 32'd2);
    repeat (4) step();
    #2 rst = 1'b0;
    #1;
    n_vec++; if ({busy, done, hi_we, lo_we} !== 4'b0000) begin n_err++; $display("FAIL rstmid_ctl: got %b want 0000", {busy, done, hi_we, lo_we}); end
    n_vec++; if ({hi_wdata, lo_wdata} !== 64'd0) begin n_err++; $display("FAIL rstmid_data: got %h want 0", {hi_wdata, lo_wdata}); end
    rst = 1'b1;
    step();
    issue(MULTU, 32'd3, 32'd4);
    wait_done(1, 20, c, bl);
    n_vec++; if (c !== 2)                 begin n_err++; $display("FAIL rstmid_mul_cycle: got %0d want 2", c); end
    n_vec++; if (lo_wdata !== 32'd12)     begin n_err++; $display("FAIL rstmid_mul_lo: got %0d want 12", lo_wdata); end
    n_vec++; if (hi_wdata !== 32'd0)      begin n_err++; $display("FAIL rstmid_mul_hi: got %0d want 0", hi_wdata); end
    step();
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_special();
    test_mthi_mtlo();
    test_busy_ignore();
    test_flush();
    test_illegal();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Multi-cycle MIPS multiply/divide execution unit. Sits directly upstream of the HI and LO registers and produces their write data and write enables.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Holds the pipeline via `busy` while an operation is in flight.
- Drives exactly one write pulse per completed operation.

Parameters:
- MUL_LAT, 2: cycles from accept to result for MULT/MULTU. Legal range is 1..8.
- DIV_ITER, 32: restoring-divide iterations, one quotient bit per cycle. Fixed at the data width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  request to begin operation `op`; sampled only when `busy`=0
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 illegal
- src_a  in  32  rs operand: multiplicand, dividend, or MTHI/MTLO data
- src_b  in  32  rt operand: multiplier or divisor; ignored for MTHI/MTLO
- flush  in  1  synchronous abort (exception or branch squash)
- busy  out  1  high while an operation is in flight
- done  out  1  one-cycle pulse in the completion cycle
- hi_wdata  out  32  data for the HI register
- lo_wdata  out  32  data for the LO register
- hi_we  out  1  HI write enable, one-cycle pulse
- lo_we  out  1  LO write enable, one-cycle pulse

Behaviour:
- Reset (`rst`=0, asynchronous):
  - state=IDLE.
  - busy, done, hi_we and lo_we = 0.
  - hi_wdata, lo_wdata and all internal operand, counter and remainder registers = 0.
- States: IDLE, MUL, DIV, FIX, DONE.
- Accept rule: on a rising edge with state=IDLE, start=1, flush=0 and a legal op:
  - Latch op, src_a and src_b.
  - Call that edge cycle 0.
  - start with an illegal op is dropped silently. No state change, no write.
- busy:
  - Registered; equals (state != IDLE).
  - Rises the cycle after accept.
  - Falls the cycle after DONE.
- IDLE → MUL for MULT/MULTU:
  - Counter loads MUL_LAT-1 and decrements each cycle.
  - At 0, go to DONE. done is then high in cycle MUL_LAT.
  - Product is 64-bit. Signed (two's complement) for MULT, unsigned for MULTU.
  - HI = product[63:32], LO = product[31:0].
- IDLE → DIV for DIV/DIVU:
  - Operands are converted to magnitudes; DIVU treats both as unsigned.
  - DIV_ITER restoring shift/subtract iterations, one per cycle, in cycles 1..32.
  - Then FIX (cycle 33) applies signs:
    - quotient negated iff signs differ (DIV only);
    - remainder takes the dividend sign.
  - DONE in cycle 34. LO = quotient, HI = remainder.
- Divide by zero:
  - Still takes the full 34 cycles.
  - LO = 32'hFFFFFFFF, HI = src_a as latched.
- Overflow case (DIV 0x80000000 / 0xFFFFFFFF): LO = 0x80000000, HI = 0. Natural wrap.
- MTHI / MTLO:
  - IDLE → DONE directly, so done is in cycle 1.
  - MTHI: hi_wdata = src_a and only hi_we pulses.
  - MTLO: lo_wdata = src_a and only lo_we pulses.
- DONE:
  - done=1 for exactly one cycle.
  - hi_we and lo_we are both 1 for mul/div ops.
  - hi_wdata and lo_wdata are valid in the same cycle.
  - Next state is IDLE.
  - Data outputs hold their last value afterwards.
- Back-to-back operations: a new start is accepted on the first edge where state=IDLE, i.e. the cycle after DONE. start while busy=1 is ignored and is not queued.
- Flush:
  - flush=1 at any edge forces state to IDLE at that edge.
  - done, hi_we and lo_we are forced to 0 in the flush cycle, including when it coincides with DONE.
  - flush together with start in IDLE: start is not accepted.
- Reset mid-operation: abort immediately. No write is produced.
- Operands changing after accept have no effect.

Test Plan:
- MULT, src_a=0xFFFFFFFE (-2), src_b=0x00000003, MUL_LAT=2 → done/hi_we/lo_we high in cycle 2, HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- DIV, src_a=0xFFFFFFF9 (-7), src_b=2 → busy for cycles 1..34, done in cycle 34, LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU, 100/7 → LO=14, HI=2.
- DIVU, src_a=0x12345678, src_b=0 → done in cycle 34, LO=0xFFFFFFFF, HI=0x12345678. DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- MTHI, src_a=0xDEADBEEF → cycle 1: hi_we=1, lo_we=0, hi_wdata=0xDEADBEEF. Immediate MTLO the next cycle is accepted. A start issued while busy during a DIV is ignored, with no extra done.
- DIV started, flush at cycle 10 → busy=0 from cycle 11, no we pulse ever. Flush coinciding with the DONE cycle → no we pulse.
- rst driven low asynchronously mid-DIV (cycle 5) → busy, done and we fall immediately, data outputs = 0. After release, a MULTU 3×4 gives LO=12, HI=0.
